// File: rtl/mag_ambm_pipe_pkg.sv
// Shared types and coefficient tables for the AMBM magnitude estimators.
// Coefficients are unsigned Q2.8; segment ratios are unsigned Q0.8 of min/max.
package mag_ambm_pipe_pkg;

    localparam int AMBM_SEG_N = 9;
    localparam int AMBM_FRAC  = 8;

    typedef logic [7:0] ratio_t;
    typedef logic [9:0] ambm_t;

    typedef enum logic [1:0] {
        MODE_AMBM = 2'd0,
        MODE_HALF = 2'd1,
        MODE_MAX  = 2'd2,
        MODE_RSVD = 2'd3
    } mag_mode_e;

    // Upper ratio bound of each segment; the last segment is open-ended.
    localparam ratio_t AMBM_SEG [AMBM_SEG_N-1] = '{
        8'h19, 8'h33, 8'h4E, 8'h6A, 8'h89, 8'hAB, 8'hC8, 8'hD2
    };

    localparam ambm_t AMBM_ALPHA [AMBM_SEG_N] = '{
        10'h133, 10'h0FE, 10'h0FA, 10'h0F3, 10'h0EA,
        10'h0DF, 10'h0D1, 10'h0D1, 10'h0B5
    };

    localparam ambm_t AMBM_BETA [AMBM_SEG_N] = '{
        10'h006, 10'h01F, 10'h038, 10'h050, 10'h068,
        10'h07E, 10'h093, 10'h093, 10'h0B4
    };

    localparam ambm_t ALPHA_UNITY = 10'h100;
    localparam ambm_t BETA_HALF   = 10'h080;

endpackage

// File: rtl/mag_seg_sel.sv
// Combinational AMBM segment selector: picks alpha/beta from the min/max ratio
// by cross-multiplied compares, so no divider is needed.
module mag_seg_sel
    import mag_ambm_pipe_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic [IN_W-1:0] max_val,
    input  logic [IN_W-1:0] min_val,
    output ambm_t           alpha,
    output ambm_t           beta
);

    localparam int CMP_W = IN_W + AMBM_FRAC;

    logic [CMP_W-1:0] left;
    logic [CMP_W-1:0] right;
    logic [3:0]       seg;

    // Scan from the top segment down so the lowest matching segment wins.
    always_comb begin
        left  = {min_val, {AMBM_FRAC{1'b0}}};
        right = '0;
        seg   = 4'(AMBM_SEG_N - 1);
        for (int k = AMBM_SEG_N - 2; k >= 0; k--) begin
            right = CMP_W'(max_val) * CMP_W'(AMBM_SEG[k]);
            if (left < right) begin
                seg = 4'(k);
            end
        end
    end

    always_comb begin
        alpha = AMBM_ALPHA[seg];
        beta  = AMBM_BETA[seg];
        if (max_val == '0) begin
            alpha = '0;
            beta  = '0;
        end
    end

endmodule

// File: rtl/mag_ambm_pipe.sv
// Three-stage alpha-max-plus-beta-min magnitude estimator with valid/ready
// flow control, channel tag sideband, per-beat mode and saturating output.
module mag_ambm_pipe
    import mag_ambm_pipe_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int OUT_W = 14,
    parameter int TAG_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_re,
    input  logic signed [IN_W-1:0] in_im,
    input  logic [1:0]             in_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_mag,
    output logic                   out_sat,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int SUM_W  = IN_W + 2;
    localparam int PROD_W = IN_W + $bits(ambm_t);
    localparam int LIM_W  = SUM_W + OUT_W;

    // The most negative input has no positive twin, so it clips to max positive.
    function automatic logic [IN_W-1:0] abs_sat(input logic signed [IN_W-1:0] v);
        logic signed [IN_W-1:0] most_neg;
        most_neg = {1'b1, {(IN_W-1){1'b0}}};
        if (v == most_neg) begin
            return {1'b0, {(IN_W-1){1'b1}}};
        end
        return v[IN_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [SUM_W-1:0] scale(input ambm_t coef, input logic [IN_W-1:0] x);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(coef) * PROD_W'(x);
        return prod[PROD_W-1:AMBM_FRAC];
    endfunction

    // Returns {sat, mag}; compare is done wide enough for any OUT_W.
    function automatic logic [OUT_W:0] sat_mag(input logic [SUM_W-1:0] s);
        logic [LIM_W-1:0] ext;
        logic [LIM_W-1:0] lim;
        ext = LIM_W'(s);
        lim = {{SUM_W{1'b0}}, {OUT_W{1'b1}}};
        if (ext > lim) begin
            return {1'b1, {OUT_W{1'b1}}};
        end
        return {1'b0, OUT_W'(s)};
    endfunction

    logic en;
    logic vld_p0, vld_p1, vld_p2;

    logic [IN_W-1:0]  ax, ay;
    logic [IN_W-1:0]  max_p0, min_p0;
    mag_mode_e        mode_p0;
    logic [TAG_W-1:0] tag_p0;

    ambm_t            seg_alpha, seg_beta;
    ambm_t            alpha_s, beta_s;
    ambm_t            alpha_p1, beta_p1;
    logic [IN_W-1:0]  max_p1, min_p1;
    logic [TAG_W-1:0] tag_p1;

    logic [SUM_W-1:0] sum_s;
    logic [OUT_W:0]   res_s;

    assign en        = !vld_p2 || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;

    // ---- stage 0: absolute values and max/min ordering ----
    assign ax = abs_sat(in_re);
    assign ay = abs_sat(in_im);

    always_ff @(posedge clk) begin
        if (en) begin
            max_p0  <= (ax >= ay) ? ax : ay;
            min_p0  <= (ax >= ay) ? ay : ax;
            mode_p0 <= mag_mode_e'(in_mode);
            tag_p0  <= in_tag;
        end
    end

    // ---- stage 1: coefficient selection ----
    mag_seg_sel #(
        .IN_W (IN_W)
    ) u_seg_sel (
        .max_val (max_p0),
        .min_val (min_p0),
        .alpha   (seg_alpha),
        .beta    (seg_beta)
    );

    always_comb begin
        alpha_s = seg_alpha;
        beta_s  = seg_beta;
        case (mode_p0)
            MODE_HALF: begin
                alpha_s = ALPHA_UNITY;
                beta_s  = BETA_HALF;
            end
            MODE_MAX: begin
                alpha_s = ALPHA_UNITY;
                beta_s  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (en) begin
            alpha_p1 <= alpha_s;
            beta_p1  <= beta_s;
            max_p1   <= max_p0;
            min_p1   <= min_p0;
            tag_p1   <= tag_p0;
        end
    end

    // ---- stage 2: weighted sum and saturation ----
    assign sum_s = scale(alpha_p1, max_p1) + scale(beta_p1, min_p1);
    assign res_s = sat_mag(sum_s);

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            out_mag <= '0;
            out_sat <= 1'b0;
            out_tag <= '0;
        end else if (en) begin
            vld_p0  <= in_valid;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            out_mag <= res_s[OUT_W-1:0];
            out_sat <= res_s[OUT_W];
            out_tag <= tag_p1;
        end
    end

endmodule

// File: tb/tb_mag_ambm_pipe.sv
// Self-checking bench for mag_ambm_pipe: directed corner beats, a random
// stream with a downstream stall, and a mid-flight reset.
module tb_mag_ambm_pipe;

    localparam int IN_W  = 14;
    localparam int OUT_W = 14;
    localparam int TAG_W = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_re;
    logic signed [IN_W-1:0] in_im;
    logic [1:0]             in_mode;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_mag;
    logic                   out_sat;
    logic [TAG_W-1:0]       out_tag;

    logic                   in_ready_n;
    logic                   out_valid_n;
    logic [12:0]            out_mag_n;
    logic                   out_sat_n;
    logic [TAG_W-1:0]       out_tag_n;

    mag_ambm_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
        .out_sat(out_sat), .out_tag(out_tag)
    );

    mag_ambm_pipe #(.IN_W(IN_W), .OUT_W(13), .TAG_W(TAG_W)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_re(in_re), .in_im(in_im), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_mag(out_mag_n),
        .out_sat(out_sat_n), .out_tag(out_tag_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int sat;
        int mag_n;
        int sat_n;
        int tag;
        int acc;
    } exp_t;

    int   ref_seg   [8] = '{25, 51, 78, 106, 137, 171, 200, 210};
    int   ref_alpha [9] = '{307, 254, 250, 243, 234, 223, 209, 209, 181};
    int   ref_beta  [9] = '{6, 31, 56, 80, 104, 126, 147, 147, 180};

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pops  = 0;
    bit   accepted;
    bit   chk_lat;
    bit   saw_nrdy;
    bit   hold;
    logic [OUT_W-1:0] hold_mag;
    logic [TAG_W-1:0] hold_tag;
    int   last_mag, last_sat, last_tag, last_mag_n, last_sat_n;

    // Magnitude from the estimator's definition, using plain integer arithmetic.
    function automatic exp_t model(input int re, input int im, input int mode, input int tag);
        exp_t e;
        int ax, ay, mx, mn, a, b, seg, s;
        ax = (re < 0) ? -re : re;
        ay = (im < 0) ? -im : im;
        if (ax > 8191) ax = 8191;
        if (ay > 8191) ay = 8191;
        mx = (ax >= ay) ? ax : ay;
        mn = (ax >= ay) ? ay : ax;
        if (mode == 1) begin
            a = 256; b = 128;
        end else if (mode == 2) begin
            a = 256; b = 0;
        end else begin
            seg = 8;
            for (int k = 0; k < 8; k++) begin
                if (mn * 256 < mx * ref_seg[k]) begin
                    seg = k;
                    break;
                end
            end
            a = ref_alpha[seg];
            b = ref_beta[seg];
            if (mx == 0) begin
                a = 0; b = 0;
            end
        end
        s = (a * mx) / 256 + (b * mn) / 256;
        e.mag   = (s > 16383) ? 16383 : s;
        e.sat   = (s > 16383) ? 1 : 0;
        e.mag_n = (s > 8191) ? 8191 : s;
        e.sat_n = (s > 8191) ? 1 : 0;
        e.tag   = tag;
        e.acc   = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, expv);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance past the edge.
    task automatic tick();
        exp_t e;
        bit   rst_edge;
        @(negedge clk);
        accepted = 0;
        if (hold) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_mag", 32'(out_mag), 32'(hold_mag));
            chk("stall_tag", 32'(out_tag), 32'(hold_tag));
        end
        if (in_ready !== 1'b1) saw_nrdy = 1;
        if (in_valid && in_ready === 1'b1) begin
            e = model(int'(in_re), int'(in_im), int'(in_mode), int'(in_tag));
            e.acc = cyc;
            exp_q.push_back(e);
            accepted = 1;
        end
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                pops++;
                chk("out_mag", 32'(out_mag), e.mag);
                chk("out_sat", 32'(out_sat), e.sat);
                chk("out_tag", 32'(out_tag), e.tag);
                chk("n_valid", 32'(out_valid_n), 1);
                chk("n_mag", 32'(out_mag_n), e.mag_n);
                chk("n_sat", 32'(out_sat_n), e.sat_n);
                chk("n_tag", 32'(out_tag_n), e.tag);
                if (chk_lat) chk("latency", cyc - e.acc, 3);
                last_mag   = int'(out_mag);
                last_sat   = int'(out_sat);
                last_tag   = int'(out_tag);
                last_mag_n = int'(out_mag_n);
                last_sat_n = int'(out_sat_n);
            end
        end
        hold     = (out_valid === 1'b1) && !out_ready;
        hold_mag = out_mag;
        hold_tag = out_tag;
        rst_edge = !rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_edge) begin
            exp_q.delete();
            hold = 0;
        end
    endtask

    task automatic send(input int re, input int im, input int mode, input int tag);
        int n;
        n        = 0;
        in_re    = IN_W'(re);
        in_im    = IN_W'(im);
        in_mode  = 2'(mode);
        in_tag   = TAG_W'(tag);
        in_valid = 1;
        tick();
        while (!accepted && n < 20) begin
            tick();
            n++;
        end
        chk("send_accept", 32'(accepted), 1);
        in_valid = 0;
    endtask

    task automatic drain();
        int n;
        n        = 0;
        in_valid = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, it, pops0;
        int cur_re, cur_im, cur_mode, cur_tag;

        rst = 0; in_valid = 0; in_re = '0; in_im = '0; in_mode = '0; in_tag = '0;
        out_ready = 1; hold = 0; chk_lat = 1; saw_nrdy = 0;
        @(posedge clk); #1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_mag", 32'(out_mag), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_n_valid", 32'(out_valid_n), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_in_ready_n", 32'(in_ready_n), 1);
        rst = 1;

        send(16'h0300, 16'h0400, 0, 1); drain();
        chk("seg6_mag", last_mag, 1277);
        chk("seg6_sat", last_sat, 0);
        chk("seg6_tag", last_tag, 1);

        send(0, 0, 0, 2); drain();
        chk("zero_mag", last_mag, 0);

        send(-8192, 0, 0, 3); drain();
        chk("most_neg_mag", last_mag, 9822);

        send(8191, 8191, 0, 4); drain();
        chk("tie_mode0", last_mag, 11550);
        send(8191, 8191, 1, 4); drain();
        chk("tie_mode1", last_mag, 12286);
        send(8191, 8191, 2, 4); drain();
        chk("tie_mode2", last_mag, 8191);

        send(8191, 0, 0, 6); drain();
        chk("wide_no_sat", last_mag, 9822);
        chk("narrow_sat_mag", last_mag_n, 8191);
        chk("narrow_sat_flag", last_sat_n, 1);

        send(16'h0300, -16'sh0400, 2, 5); drain();
        chk("mode2_mag", last_mag, 1024);
        chk("mode2_tag", last_tag, 5);
        send(16'h0300, 16'h0400, 3, 7); drain();
        chk("mode3_mag", last_mag, 1277);

        // Random stream with a five-cycle downstream stall in the middle.
        chk_lat  = 0;
        saw_nrdy = 0;
        sent     = 0;
        it       = 0;
        pops0    = pops;
        cur_re   = int'($signed(14'($urandom)));
        cur_im   = int'($signed(14'($urandom)));
        cur_mode = int'($urandom_range(0, 3));
        cur_tag  = int'($urandom_range(0, 7));
        while (sent < 20 && it < 200) begin
            in_valid  = 1;
            in_re     = IN_W'(cur_re);
            in_im     = IN_W'(cur_im);
            in_mode   = 2'(cur_mode);
            in_tag    = TAG_W'(cur_tag);
            out_ready = !(it >= 8 && it < 13);
            tick();
            it++;
            if (accepted) begin
                sent++;
                cur_re   = int'($signed(14'($urandom)));
                cur_im   = int'($signed(14'($urandom)));
                cur_mode = int'($urandom_range(0, 3));
                cur_tag  = int'($urandom_range(0, 7));
            end
        end
        chk("stream_sent", sent, 20);
        out_ready = 1;
        drain();
        chk("stream_pops", pops - pops0, 20);
        chk("stall_in_ready_low", 32'(saw_nrdy), 1);

        // Reset with three beats in flight; none of them may surface.
        out_ready = 0;
        send(100, 200, 0, 1);
        send(300, 400, 1, 2);
        send(500, 600, 2, 3);
        rst = 0;
        tick();
        rst = 1;
        out_ready = 1;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        pops0 = pops;
        for (int i = 0; i < 4; i++) tick();
        chk("flush_no_pops", pops - pops0, 0);
        chk_lat = 1;
        send(16'h0300, 16'h0400, 0, 2); drain();
        chk("post_rst_mag", last_mag, 1277);
        chk("post_rst_tag", last_tag, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
